gpioemu_mulpop: RTL and testbench



---
 rtl/gpioemu_mulpop.sv | 183 ++++++++++++++++++
 tb/tb_gpioemu_mulpop.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_mulpop.sv
// rtl/gpioemu_mulpop.sv - bus-mapped sequential multiply + popcount peripheral
module gpioemu_mulpop #(
  parameter int          ARG_W = 24,
  parameter int          RES_W = 32,
  parameter int          CNT_W = 16,
  parameter logic [15:0] BASE  = 16'h0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic [31:0] gpio_out,
  output logic        done_pulse
);

  localparam int AW2 = 2 * ARG_W;
  localparam int LW  = $clog2(RES_W + 1);
  localparam int IW  = $clog2(ARG_W + 1);

  localparam logic [15:0] ADDR_ARG1 = BASE;
  localparam logic [15:0] ADDR_ARG2 = BASE + 16'h0008;
  localparam logic [15:0] ADDR_W    = BASE + 16'h0010;
  localparam logic [15:0] ADDR_L    = BASE + 16'h0018;
  localparam logic [15:0] ADDR_CTRL = BASE + 16'h0020;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_COUNT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic             srd_q, swr_q;
  logic             rd_edge, wr_edge;
  logic             sel_arg1, sel_arg2, sel_w, sel_l, sel_ctrl;
  logic             start;
  logic             busy, done, valid;
  logic [ARG_W-1:0] a1, a2;
  logic [AW2-1:0]   acc;
  logic [AW2-1:0]   m1;
  logic [ARG_W-1:0] m2;
  logic [IW-1:0]    bit_idx;
  logic             last_bit;
  logic [RES_W-1:0] w;
  logic [LW-1:0]    l;
  logic [CNT_W-1:0] op_count;
  logic [31:0]      rd_data;
  logic             do_start, do_mult, do_count, do_done;
  logic             unused_sdata;

  function automatic logic [LW-1:0] popcount(input logic [RES_W-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int k = 0; k < RES_W; k++) begin
      n = n + LW'(v[k]);
    end
    return n;
  endfunction

  // Accesses happen only on the rising edge of a strobe, so a held strobe acts once.
  assign rd_edge  = srd & ~srd_q;
  assign wr_edge  = swr & ~swr_q;

  assign sel_arg1 = (saddress == ADDR_ARG1);
  assign sel_arg2 = (saddress == ADDR_ARG2);
  assign sel_w    = (saddress == ADDR_W);
  assign sel_l    = (saddress == ADDR_L);
  assign sel_ctrl = (saddress == ADDR_CTRL);

  assign start    = wr_edge & sel_ctrl;
  assign busy     = (state != S_IDLE);
  assign last_bit = (bit_idx == IW'(ARG_W - 1));
  assign gpio_out = 32'(op_count);

  assign unused_sdata = ^sdata_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MULT;
      S_MULT:  if (last_bit) state_nxt = S_COUNT;
      S_COUNT: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    do_start = 1'b0;
    do_mult  = 1'b0;
    do_count = 1'b0;
    do_done  = 1'b0;
    case (state)
      S_IDLE:  do_start = start;
      S_MULT:  do_mult  = 1'b1;
      S_COUNT: do_count = 1'b1;
      S_DONE:  do_done  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (sel_arg1) rd_data = 32'(a1);
    if (sel_arg2) rd_data = 32'(a2);
    if (sel_w)    rd_data = 32'(w);
    if (sel_l)    rd_data = 32'(l);
    if (sel_ctrl) rd_data = {29'b0, busy, done, valid};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srd_q      <= 1'b0;
      swr_q      <= 1'b0;
      a1         <= '0;
      a2         <= '0;
      acc        <= '0;
      m1         <= '0;
      m2         <= '0;
      bit_idx    <= '0;
      w          <= '0;
      l          <= '0;
      valid      <= 1'b1;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      op_count   <= '0;
      sdata_out  <= '0;
    end else begin
      srd_q      <= srd;
      swr_q      <= swr;
      done_pulse <= do_done;

      // Operand registers are frozen while an operation is in flight.
      if (wr_edge && !busy) begin
        if (sel_arg1) a1 <= sdata_in[ARG_W-1:0];
        if (sel_arg2) a2 <= sdata_in[ARG_W-1:0];
      end

      if (do_start) begin
        acc     <= '0;
        m1      <= AW2'(a1);
        m2      <= a2;
        bit_idx <= '0;
        done    <= 1'b0;
      end

      // Shifted working copies keep the visible operand registers intact.
      if (do_mult) begin
        if (m2[0]) acc <= acc + m1;
        m1      <= m1 << 1;
        m2      <= m2 >> 1;
        bit_idx <= bit_idx + IW'(1);
      end

      if (do_count) begin
        w     <= acc[RES_W-1:0];
        l     <= popcount(acc[RES_W-1:0]);
        valid <= ((acc >> RES_W) == '0);
      end

      if (do_done) begin
        done     <= 1'b1;
        op_count <= op_count + CNT_W'(1);
      end

      if (rd_edge) sdata_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// tb/tb_gpioemu_mulpop.sv - directed self-checking bench for gpioemu_mulpop
module tb_gpioemu_mulpop;

  localparam int          ARG_W  = 24;
  localparam logic [15:0] BASE   = 16'h0380;
  localparam logic [15:0] A_ARG1 = BASE;
  localparam logic [15:0] A_ARG2 = BASE + 16'h0008;
  localparam logic [15:0] A_W    = BASE + 16'h0010;
  localparam logic [15:0] A_L    = BASE + 16'h0018;
  localparam logic [15:0] A_CTRL = BASE + 16'h0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out, gpio_out;
  logic        done_pulse;
  logic [31:0] sdata_out2, gpio_out2;
  logic        done_pulse2;

  gpioemu_mulpop #(.ARG_W(ARG_W), .RES_W(32), .CNT_W(16), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_out(gpio_out),
    .done_pulse(done_pulse)
  );

  gpioemu_mulpop #(.ARG_W(ARG_W), .RES_W(32), .CNT_W(2), .BASE(BASE)) dut2 (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out2), .gpio_out(gpio_out2),
    .done_pulse(done_pulse2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] w;
    logic [31:0] l;
    logic [31:0] stat;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_ops;
  int   lat;
  int   pulses;
  logic [31:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    saddress = addr;
    sdata_in = data;
    swr      = 1'b1;
    @(negedge clk);
    swr      = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    @(negedge clk);
    saddress = addr;
    srd      = 1'b1;
    @(negedge clk);
    data     = sdata_out;
    srd      = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done_pulse !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("done_timeout", 32'(k), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y);
    bus_write(A_ARG1, x);
    bus_write(A_ARG2, y);
    bus_write(A_CTRL, 32'h0);
    wait_done(lat);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'h3,      32'h5,      32'h0000000F, 32'd4,  32'h3};
    vecs[1] = '{32'hFFFFFF, 32'hFFFFFF, 32'hFE000001, 32'd8,  32'h2};
    vecs[2] = '{32'h0,      32'h123456, 32'h0,        32'd0,  32'h3};
    vecs[3] = '{32'h100,    32'h100,    32'h00010000, 32'd1,  32'h3};
    vecs[4] = '{32'h800000, 32'h2,      32'h01000000, 32'd1,  32'h3};
    vecs[5] = '{32'h800000, 32'h800000, 32'h0,        32'd0,  32'h2};
    vecs[6] = '{32'hFFFF,   32'h10001,  32'hFFFFFFFF, 32'd32, 32'h3};
    vecs[7] = '{32'h1234,   32'h10,     32'h00012340, 32'd5,  32'h3};

    reset = 1'b1; saddress = '0; srd = 1'b0; swr = 1'b0; sdata_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    bus_read(A_ARG1, rd); check("rst_arg1", rd, 32'h0);
    bus_read(A_ARG2, rd); check("rst_arg2", rd, 32'h0);
    bus_read(A_W, rd);    check("rst_w", rd, 32'h0);
    bus_read(A_L, rd);    check("rst_l", rd, 32'h0);
    bus_read(A_CTRL, rd); check("rst_stat", rd, 32'h1);
    check("rst_gpio", gpio_out, 32'h0);
    exp_ops = 0;

    for (int i = 0; i < 8; i++) begin
      bus_write(A_ARG1, vecs[i].a1);
      bus_write(A_ARG2, vecs[i].a2);
      bus_write(A_CTRL, 32'h0);
      wait_done(lat);
      exp_ops++;
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(ARG_W + 2));
      @(negedge clk);
      check($sformatf("v%0d_pulse_width", i), 32'(done_pulse), 32'h0);
      bus_read(A_W, rd);    check($sformatf("v%0d_w", i), rd, vecs[i].w);
      bus_read(A_L, rd);    check($sformatf("v%0d_l", i), rd, vecs[i].l);
      bus_read(A_CTRL, rd); check($sformatf("v%0d_stat", i), rd, vecs[i].stat);
      bus_read(A_ARG1, rd); check($sformatf("v%0d_arg1", i), rd, vecs[i].a1);
      check($sformatf("v%0d_gpio", i), gpio_out, 32'(exp_ops));
    end

    // Writes and a second start while busy must be ignored.
    bus_write(A_ARG1, 32'h0);
    bus_write(A_ARG2, 32'h123456);
    bus_write(A_CTRL, 32'h0);
    bus_read(A_CTRL, rd); check("busy_stat", rd, 32'h5);
    bus_write(A_ARG1, 32'h7);
    bus_write(A_CTRL, 32'h0);
    wait_done(lat);
    exp_ops++;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_pulse) pulses++;
    end
    check("busy_no_restart", 32'(pulses), 32'h0);
    bus_read(A_W, rd);    check("busy_w", rd, 32'h0);
    bus_read(A_L, rd);    check("busy_l", rd, 32'h0);
    bus_read(A_CTRL, rd); check("busy_stat_end", rd, 32'h3);
    bus_read(A_ARG1, rd); check("busy_arg1_kept", rd, 32'h0);
    check("busy_gpio", gpio_out, 32'(exp_ops));

    // Reset in the middle of MULT abandons the operation.
    bus_write(A_ARG1, 32'h3);
    bus_write(A_ARG2, 32'h5);
    bus_write(A_CTRL, 32'h0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ops = 0;
    bus_read(A_ARG1, rd); check("mrst_arg1", rd, 32'h0);
    bus_read(A_ARG2, rd); check("mrst_arg2", rd, 32'h0);
    bus_read(A_W, rd);    check("mrst_w", rd, 32'h0);
    bus_read(A_L, rd);    check("mrst_l", rd, 32'h0);
    bus_read(A_CTRL, rd); check("mrst_stat", rd, 32'h1);
    check("mrst_gpio", gpio_out, 32'h0);
    check("mrst_gpio2", gpio_out2, 32'h0);

    run_op(32'h3, 32'h5);
    exp_ops++;
    bus_read(A_W, rd); check("post_rst_w", rd, 32'h0000000F);
    check("post_rst_gpio", gpio_out, 32'(exp_ops));
    check("cnt2_gpio_0", gpio_out2, 32'(exp_ops % 4));

    for (int i = 1; i <= 4; i++) begin
      run_op(32'h2, 32'h2);
      exp_ops++;
      check($sformatf("cnt2_gpio_%0d", i), gpio_out2, 32'(exp_ops % 4));
    end

    // A write strobe held high across an entire operation starts only one.
    @(negedge clk);
    saddress = A_CTRL;
    swr      = 1'b1;
    pulses   = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_pulse) pulses++;
    end
    swr = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_pulse) pulses++;
    end
    exp_ops++;
    check("held_swr_ops", 32'(pulses), 32'h1);
    check("held_swr_gpio", gpio_out, 32'(exp_ops));

    // Simultaneous read and write of ARG1 returns the old value.
    @(negedge clk);
    saddress = A_ARG1;
    sdata_in = 32'h9;
    srd      = 1'b1;
    swr      = 1'b1;
    @(negedge clk);
    check("rdwr_pre_value", sdata_out, 32'h2);
    srd = 1'b0;
    swr = 1'b0;
    bus_read(A_ARG1, rd);       check("rdwr_new_value", rd, 32'h9);
    bus_read(16'h0384, rd);     check("unmapped_read", rd, 32'h0);
    bus_write(A_W, 32'hDEAD);
    bus_read(A_W, rd);          check("ro_write_ignored", rd, 32'h4);
    bus_write(16'h03A8, 32'h1);
    bus_read(A_CTRL, rd);       check("unmapped_write", rd, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
